dual_ram_mask_clr: RTL and testbench
====================================

Name: dual_ram_mask_clr

Overview:
Single-clock simple dual-port RAM (one write port, one read port), parametrised in word width, depth and read latency.
- Write: per-lane write mask.
- Read: explicit read enable with a read_valid strobe.
- Read-during-write to the same address has a defined result.
- Optional hardware clear sweep after reset, with busy status.
- Used as the generic buffer/line store for PPU-side blocks that need known-initialised memory.

Parameters:
SIZE, 16, word width in bits; must be a multiple of LANE.
LANE, 8, bits per write-mask lane; LANES = SIZE/LANE.
DEPTH, 256, number of entries; need not be a power of two.
LATENCY, 1, read latency in cycles; legal values are 1 and 2.
BYPASS, 1, 1 = write-first on same-address collision; 0 = read-first.
CLEAR_ON_RESET, 1, 1 = sweep every entry to INIT_VALUE after reset.
INIT_VALUE, 0, SIZE-bit clear value.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
waddr  in  $clog2(DEPTH)  write address.
write_data  in  SIZE  write data.
write_mask  in  LANES  per-lane write enable; bit i covers data bits [i*LANE +: LANE].
write_en  in  1  write request.
raddr  in  $clog2(DEPTH)  read address.
read_en  in  1  read request.
read_data  out  SIZE  read result.
read_valid  out  1  one-cycle strobe; read_data is valid when high.
busy  out  1  high during reset and the clear sweep; requests are ignored while high.

Behaviour:
- States: RESET, CLEAR, RUN.
  - While rst=1: state=RESET, busy=1, read_valid=0, read_data=0, clear counter=0, latency pipeline flushed. Memory contents are not reset by rst itself.
  - First cycle with rst=0, leaving RESET:
    - CLEAR_ON_RESET=1 -> CLEAR.
    - CLEAR_ON_RESET=0 -> RUN.
  - CLEAR: each cycle writes INIT_VALUE (all lanes) to mem[cnt], then cnt++. After the write of cnt=DEPTH-1 -> RUN. The sweep takes exactly DEPTH cycles; busy=1 throughout.
  - RUN: busy=0.
  - rst asserted in any state -> RESET next edge. An interrupted sweep restarts from 0 after release.
- Requests while busy=1: write_en and read_en are dropped. No memory change, no read_valid.
- Write (RUN, write_en=1): for each lane i with write_mask[i]=1, that lane of mem[waddr] takes write_data on the edge. Unmasked lanes keep their value. write_mask=0 is a no-op.
- Read (RUN, read_en=1, accepted at edge N):
  - LATENCY=1: read_valid=1 and read_data=result during cycle N+1.
  - LATENCY=2: the same appears during cycle N+2.
  - Back-to-back reads give one result per cycle, in order.
  - read_valid is low on non-result cycles; read_data holds its last value.
- Collision (RUN, read_en and write_en in the same cycle, raddr==waddr):
  - BYPASS=1: result = new write_data on masked lanes, old contents on unmasked lanes.
  - BYPASS=0: result = old contents for all lanes.
  - Realised as a registered forward flag, registered mask and registered data, merged after the array read, so the array itself stays read-first and BRAM-inferable.
- Out of range (DEPTH not a power of two), address >= DEPTH:
  - Write is dropped.
  - Read returns INIT_VALUE with read_valid asserted as normal.
- The memory array carries no reset and no initial-value dependence. The clear sweep is the only initialisation.

Decomposition:
- Package dual_ram_pkg holds:
  - the state enum (RESET, CLEAR, RUN);
  - the LANES calculation;
  - legal-parameter checks (SIZE % LANE == 0, LATENCY in {1,2}).
- Sub-module dual_ram_lane_array: the bare storage with a lane-masked write and a registered read-first read, written so the tools infer block RAM.
- The top level owns the FSM, clear counter, arbitration between the sweep writer and the user writer, bypass merge, latency pipeline and read_valid.

Test Plan:
1. Reset then sweep (DEPTH=256, INIT_VALUE=16'hA5A5): release rst, count busy cycles, then read addresses 0, 128 and 255 -> busy=1 for exactly 256 cycles after release; each read returns 16'hA5A5 with read_valid one cycle after read_en.
2. Masked write: write 16'h1234 (mask 2'b11) to addr 5, then 16'hABCD (mask 2'b01) to addr 5, then read -> 16'h12CD.
3. Collision: hold 16'h1111 at addr 9; in one cycle write 16'h2222 (mask 2'b10) to addr 9 and read addr 9 -> BYPASS=1 returns 16'h2211; BYPASS=0 returns 16'h1111; a following read returns 16'h2211 in both cases.
4. LATENCY=2 streaming: read addresses 0..7 on consecutive cycles after writing data=addr -> read_valid high for 8 consecutive cycles starting 2 cycles after the first read_en, data 0..7 in order.
5. Reset mid-sweep: assert rst at sweep cycle 100 for 1 cycle -> busy stays high; the sweep restarts and busy falls 256 cycles after release. Writes and reads issued while busy produce no read_valid and no memory change.
6. DEPTH=200: write to addr 210, then read addr 210 -> read_data=INIT_VALUE with read_valid=1; addr 199 reads and writes normally.

Source files
------------

// File: rtl/dual_ram_pkg.sv
// Shared types and parameter helpers for the dual-port masked RAM.
// Holds the controller state encoding and elaboration-time legality checks.
package dual_ram_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int lanes_of(input int size, input int lane);
    return size / lane;
  endfunction

  // Word must split into whole lanes; read latency is either 1 or 2.
  function automatic bit params_ok(input int size, input int lane,
                                   input int latency, input int depth);
    return (lane > 0) && (size % lane == 0) && (size >= lane) &&
           (latency == 1 || latency == 2) && (depth > 1);
  endfunction

endpackage

// File: rtl/dual_ram_lane_array.sv
// Bare storage: lane-masked write port and registered read-first read port.
// Kept free of bypass/reset logic on the array so it maps onto block RAM.
module dual_ram_lane_array
  import dual_ram_pkg::*;
#(
  parameter  int SIZE  = 16,
  parameter  int LANE  = 8,
  parameter  int DEPTH = 256,
  localparam int LANES = lanes_of(SIZE, LANE),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LANES-1:0] wmask,
  input  logic [SIZE-1:0]  wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [SIZE-1:0]  rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; a reset branch here would block
  // RAM inference. Initialisation is done by the controller's clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[waddr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
      end
    end
  end

  // NOTE: non-blocking read of mem in the same edge as the write gives
  // read-first (old data) behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_ram_mask_clr.sv
// Simple dual-port RAM with per-lane write mask, optional post-reset clear
// sweep, write-first/read-first collision handling and 1- or 2-cycle reads.
module dual_ram_mask_clr
  import dual_ram_pkg::*;
#(
  parameter  int              SIZE           = 16,
  parameter  int              LANE           = 8,
  parameter  int              DEPTH          = 256,
  parameter  int              LATENCY        = 1,
  parameter  int              BYPASS         = 1,
  parameter  int              CLEAR_ON_RESET = 1,
  parameter  logic [SIZE-1:0] INIT_VALUE     = '0,
  localparam int              LANES          = lanes_of(SIZE, LANE),
  localparam int              AW             = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    waddr,
  input  logic [SIZE-1:0]  write_data,
  input  logic [LANES-1:0] write_mask,
  input  logic             write_en,
  input  logic [AW-1:0]    raddr,
  input  logic             read_en,
  output logic [SIZE-1:0]  read_data,
  output logic             read_valid,
  output logic             busy
);

  if (!params_ok(SIZE, LANE, LATENCY, DEPTH)) begin : g_bad_params
    $error("dual_ram_mask_clr: illegal SIZE/LANE/LATENCY/DEPTH combination");
  end

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic            active;
  logic            sweeping;
  logic            user_wr;
  logic            rd_acc;
  logic            rd_in_range;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [SIZE-1:0] arr_wdata;
  logic [LANES-1:0] arr_wmask;
  logic [SIZE-1:0] arr_rdata;
  logic            rd_v1, fwd1, oor1;
  logic [LANES-1:0] fmask1;
  logic [SIZE-1:0] fdata1;
  logic [SIZE-1:0] merged;

  assign active      = !rst && (state == RUN);
  assign busy        = !active;
  assign sweeping    = !rst && (state == CLEAR);
  assign rd_in_range = {1'b0, raddr} < DEPTH_W;
  assign user_wr     = active && write_en && ({1'b0, waddr} < DEPTH_W);
  assign rd_acc      = active && read_en;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  // The sweep owns the write port while it runs; user writes are gated by busy.
  always_comb begin
    arr_we    = user_wr;
    arr_waddr = waddr;
    arr_wdata = write_data;
    arr_wmask = write_mask;
    if (sweeping) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt;
      arr_wdata = INIT_VALUE;
      arr_wmask = '1;
    end
  end

  dual_ram_lane_array #(
    .SIZE  (SIZE),
    .LANE  (LANE),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wmask (arr_wmask),
    .wdata (arr_wdata),
    .re    (rd_acc),
    .raddr (raddr),
    .rdata (arr_rdata)
  );

  // Side-band captured with each accepted read; only updated on a read so the
  // merged result holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1  <= 1'b0;
      fwd1   <= 1'b0;
      oor1   <= 1'b0;
      fmask1 <= '0;
      fdata1 <= '0;
    end else begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        oor1   <= !rd_in_range;
        fwd1   <= (BYPASS != 0) && user_wr && (waddr == raddr);
        fmask1 <= write_mask;
        fdata1 <= write_data;
      end
    end
  end

  always_comb begin
    merged = arr_rdata;
    for (int i = 0; i < LANES; i++) begin
      if (fwd1 && fmask1[i]) merged[i*LANE +: LANE] = fdata1[i*LANE +: LANE];
    end
    if (oor1) merged = INIT_VALUE;
  end

  if (LATENCY == 2) begin : g_lat2
    logic [SIZE-1:0] rd_q;
    logic            rv_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_v1;
        if (rd_v1) rd_q <= merged;
      end
    end
    assign read_data  = rd_q;
    assign read_valid = rv_q;
  end else begin : g_lat1
    assign read_data  = merged;
    assign read_valid = rd_v1;
  end

endmodule

// File: tb/tb_dual_ram_mask_clr.sv
// Self-checking bench: two configurations share one stimulus stream and are
// compared every cycle against a queue-based model, plus literal spot checks.
module tb_dual_ram_mask_clr;

  localparam int          DEPTHS [2] = '{256, 200};
  localparam int          LATS   [2] = '{1, 2};
  localparam int          BYPS   [2] = '{1, 0};
  localparam logic [15:0] INITS  [2] = '{16'hA5A5, 16'h5A5A};

  typedef struct packed {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  waddr, raddr;
  logic [15:0] write_data;
  logic [1:0]  write_mask;
  logic        write_en, read_en;
  logic [15:0] rd [2];
  logic        rv [2];
  logic        bz [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          started = 1'b0;
  int          rem [2] = '{0, 0};
  logic [15:0] last_rd [2] = '{16'h0, 16'h0};
  logic [15:0] mm [2][256];
  exp_t        q0 [$];
  exp_t        q1 [$];

  always #5 clk = ~clk;

  dual_ram_mask_clr #(
    .SIZE(16), .LANE(8), .DEPTH(256), .LATENCY(1), .BYPASS(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5)
  ) u0 (
    .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data),
    .write_mask(write_mask), .write_en(write_en), .raddr(raddr),
    .read_en(read_en), .read_data(rd[0]), .read_valid(rv[0]), .busy(bz[0])
  );

  dual_ram_mask_clr #(
    .SIZE(16), .LANE(8), .DEPTH(200), .LATENCY(2), .BYPASS(0),
    .CLEAR_ON_RESET(1), .INIT_VALUE(16'h5A5A)
  ) u1 (
    .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data),
    .write_mask(write_mask), .write_en(write_en), .raddr(raddr),
    .read_en(read_en), .read_data(rd[1]), .read_valid(rv[1]), .busy(bz[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: busy is a countdown of remaining sweep cycles; accepted reads are
  // queued with the edge after which their result must be visible.
  task automatic model_edge(input int k);
    logic [15:0] val;
    exp_t        e;
    bit          acc;
    if (rst) begin
      rem[k]     = DEPTHS[k] + 1;
      last_rd[k] = 16'h0;
      if (k == 0) q0.delete(); else q1.delete();
      started = 1'b1;
      return;
    end
    acc = started && (rem[k] == 0);
    if (rem[k] > 0) begin
      rem[k]--;
      if (rem[k] == 0) for (int a = 0; a < 256; a++) mm[k][a] = INITS[k];
    end
    if (!acc) return;
    if (read_en) begin
      if (int'(raddr) >= DEPTHS[k]) val = INITS[k];
      else begin
        val = mm[k][raddr];
        if (BYPS[k] != 0 && write_en && waddr == raddr)
          for (int l = 0; l < 2; l++)
            if (write_mask[l]) val[l*8 +: 8] = write_data[l*8 +: 8];
      end
      e.d   = val;
      e.due = cyc + LATS[k] - 1;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (write_en && int'(waddr) < DEPTHS[k])
      for (int l = 0; l < 2; l++)
        if (write_mask[l]) mm[k][waddr][l*8 +: 8] = write_data[l*8 +: 8];
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) model_edge(k);
    end
  end

  initial begin
    exp_t e;
    bit   hit;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          hit = 1'b0;
          if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
          if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
          check($sformatf("busy%0d", k), 32'(bz[k]), 32'(rst || rem[k] > 0));
          if (hit) begin
            check($sformatf("valid%0d", k), 32'(rv[k]), 32'(1));
            check($sformatf("data%0d", k), 32'(rd[k]), 32'(e.d));
            last_rd[k] = e.d;
          end else begin
            check($sformatf("idle_valid%0d", k), 32'(rv[k]), 32'(0));
            check($sformatf("hold%0d", k), 32'(rd[k]), 32'(last_rd[k]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
    waddr = a; write_data = d; write_mask = m; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  // One read; u0 (latency 1) answers in the next cycle, u1 (latency 2) one later.
  task automatic rd_lit(input string name, input logic [7:0] a,
                        input logic [15:0] e0, input logic [15:0] e1);
    raddr = a; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    @(negedge clk);
    check({name, "_u0_valid"}, 32'(rv[0]), 32'(1));
    check({name, "_u0_data"}, 32'(rd[0]), 32'(e0));
    tick();
    @(negedge clk);
    check({name, "_u1_valid"}, 32'(rv[1]), 32'(1));
    check({name, "_u1_data"}, 32'(rd[1]), 32'(e1));
    tick();
  endtask

  // Counts busy cycles per instance after a release edge; bounded at 400.
  task automatic count_busy(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bz[0]) c0++;
      if (bz[1]) c1++;
      if (!bz[0] && !bz[1]) begin
        write_en = 1'b0;
        read_en  = 1'b0;
        break;
      end
    end
    tick();
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1; waddr = '0; raddr = '0; write_data = '0; write_mask = '0;
    write_en = 1'b0; read_en = 1'b0;
    repeat (3) tick();

    // Reset release and full sweep.
    rst = 1'b0;
    @(posedge clk);
    count_busy(c0, c1);
    check("sweep_busy_u0", 32'(c0), 32'd256);
    check("sweep_busy_u1", 32'(c1), 32'd200);
    rd_lit("init0", 8'd0, 16'hA5A5, 16'h5A5A);
    rd_lit("init128", 8'd128, 16'hA5A5, 16'h5A5A);
    rd_lit("init255", 8'd255, 16'hA5A5, 16'h5A5A);

    // Masked write.
    wr(8'd5, 16'h1234, 2'b11);
    wr(8'd5, 16'hABCD, 2'b01);
    check("model_pin_mask", 32'(mm[0][5]), 32'h12CD);
    rd_lit("mask", 8'd5, 16'h12CD, 16'h12CD);

    // Same-address collision: u0 write-first, u1 read-first.
    wr(8'd9, 16'h1111, 2'b11);
    waddr = 8'd9; write_data = 16'h2222; write_mask = 2'b10; write_en = 1'b1;
    raddr = 8'd9; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    @(negedge clk);
    check("coll_bypass_u0", 32'(rd[0]), 32'h2211);
    tick();
    @(negedge clk);
    check("coll_readfirst_u1", 32'(rd[1]), 32'h1111);
    tick();
    rd_lit("after_coll", 8'd9, 16'h2211, 16'h2211);

    // Streaming reads on u1 (latency 2).
    for (int i = 0; i < 8; i++) wr(8'(i), 16'(i), 2'b11);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin raddr = 8'(i); read_en = 1'b1; end
      else read_en = 1'b0;
      @(negedge clk);
      if (i == 1) check("stream_no_early", 32'(rv[1]), 32'(0));
      if (i >= 2) begin
        check("stream_valid", 32'(rv[1]), 32'(1));
        check("stream_data", 32'(rd[1]), 32'(i - 2));
      end
      tick();
    end

    // Out-of-range on u1 (DEPTH 200), last legal entry on both.
    wr(8'd210, 16'h7777, 2'b11);
    rd_lit("oor210", 8'd210, 16'h7777, 16'h5A5A);
    wr(8'd199, 16'h1999, 2'b11);
    rd_lit("edge199", 8'd199, 16'h1999, 16'h1999);

    // Reset mid-sweep, with requests held throughout the busy window.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waddr = 8'd0; write_data = 16'hFFFF; write_mask = 2'b11; write_en = 1'b1;
    raddr = 8'd0; read_en = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    @(posedge clk);
    count_busy(c0, c1);
    check("resweep_busy_u0", 32'(c0), 32'd256);
    check("resweep_busy_u1", 32'(c1), 32'd200);
    rd_lit("busy_drop", 8'd0, 16'hA5A5, 16'hFFFF);

    // Randomised traffic biased to a small window and the out-of-range region.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 999) == 0);
      write_en   = 1'($urandom_range(0, 1));
      read_en    = 1'($urandom_range(0, 1));
      waddr      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
      raddr      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) raddr = waddr;
      write_data = 16'($urandom);
      write_mask = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
